rv32i_operand_fetch: RTL

Operand-fetch stage between decode and execute. Accepts one instruction's source indices (rs1, rs2) and reads both operands in turn through the single read port of the `rv32i_gpr` block-RAM register file. It also owns that RAM's write port for write-back, suppresses writes to x0, and forwards in-flight write-back data into pending operands. Operands go to execute over a valid/ready handshake.

---
 rtl/rv32i_pkg.sv | 15 +
 rtl/rv32i_opnd_slot.sv | 73 +++++++
 rtl/rv32i_operand_fetch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i front-end blocks.
package rv32i_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0 = '0;

    typedef enum logic [2:0] {
        StIdle,
        StRd1,
        StRd2,
        StDrain,
        StOut
    } opf_state_e;

endpackage

// File: rtl/rv32i_opnd_slot.sv
// One operand slot: holds a source value, captures the RAM return and
// forwards matching write-back data while the slot is live.
module rv32i_opnd_slot
    import rv32i_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue,
    input  logic                 ret,
    input  logic                 retire,
    input  logic [REG_IDX_W-1:0] idx,
    input  logic [31:0]          gpr_q,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [31:0]          wb_data,
    output logic [31:0]          data,
    output logic                 pending
);

    logic [31:0] data_q, data_d;
    logic        pending_q, pending_d;
    logic        fwd_q, fwd_d;
    logic        live_q, live_d;
    logic        is_x0;
    logic        fwd_hit;

    assign is_x0   = (idx == X0);
    assign fwd_hit = (issue || live_q) && wb_valid && (wb_rd == idx) && !is_x0;

    always_comb begin
        data_d    = data_q;
        pending_d = pending_q;
        fwd_d     = fwd_q;
        live_d    = live_q;
        if (issue) begin
            pending_d = 1'b1;
            fwd_d     = 1'b0;
            live_d    = 1'b1;
        end
        if (ret) begin
            pending_d = 1'b0;
            // A forwarded value is newer than the RAM copy still in flight.
            if (!fwd_q) begin
                data_d = is_x0 ? 32'd0 : gpr_q;
            end
        end
        if (fwd_hit) begin
            data_d = wb_data;
            fwd_d  = 1'b1;
        end
        if (retire) begin
            live_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q    <= 32'd0;
            pending_q <= 1'b0;
            fwd_q     <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            data_q    <= data_d;
            pending_q <= pending_d;
            fwd_q     <= fwd_d;
            live_q    <= live_d;
        end
    end

    assign data    = data_q;
    assign pending = pending_q;

endmodule

// File: rtl/rv32i_operand_fetch.sv
// Operand-fetch stage: reads rs1/rs2 through one block-RAM read port, owns the
// write-back port and forwards in-flight write-backs into pending operands.
module rv32i_operand_fetch
    import rv32i_pkg::*;
#(
    parameter int unsigned GPR_ADDR_WIDTH = 9,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TAG_WIDTH      = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_IDX_W-1:0]      in_rs1,
    input  logic [REG_IDX_W-1:0]      in_rs2,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    input  logic                      wb_valid,
    input  logic [REG_IDX_W-1:0]      wb_rd,
    input  logic [31:0]               wb_data,
    output logic [GPR_ADDR_WIDTH-1:0] gpr_rdaddress,
    output logic                      gpr_rden,
    output logic [GPR_ADDR_WIDTH-1:0] gpr_wraddress,
    output logic                      gpr_wren,
    output logic [31:0]               gpr_data,
    input  logic [31:0]               gpr_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_rs1_data,
    output logic [31:0]               out_rs2_data,
    output logic [TAG_WIDTH-1:0]      out_tag
);

    opf_state_e             state_q, state_d;
    logic [REG_IDX_W-1:0]   rs1_q, rs2_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   latch;
    logic                   issue1, issue2;
    logic                   rd_sel;
    logic                   retire;

    // Return pipe: vld marks a read in flight, sel says which slot it feeds.
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0] pipe_sel_q, pipe_sel_d;
    logic                    ret1, ret2;
    logic                    pend1, pend2;

    assign ret1   = pipe_vld_q[READ_LATENCY-1] && !pipe_sel_q[READ_LATENCY-1];
    assign ret2   = pipe_vld_q[READ_LATENCY-1] &&  pipe_sel_q[READ_LATENCY-1];
    assign retire = (state_q == StOut) && out_ready;

    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        gpr_rden      = 1'b0;
        gpr_rdaddress = '0;
        rd_sel        = 1'b0;
        latch         = 1'b0;
        issue1        = 1'b0;
        issue2        = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    latch   = 1'b1;
                    state_d = StRd1;
                end
            end
            StRd1: begin
                gpr_rden      = 1'b1;
                gpr_rdaddress = GPR_ADDR_WIDTH'(rs1_q);
                issue1        = 1'b1;
                state_d       = StRd2;
            end
            StRd2: begin
                gpr_rden      = 1'b1;
                gpr_rdaddress = GPR_ADDR_WIDTH'(rs2_q);
                rd_sel        = 1'b1;
                issue2        = 1'b1;
                state_d       = StDrain;
            end
            StDrain: begin
                if ((!pend1 || ret1) && (!pend2 || ret2)) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_sel_d    = pipe_sel_q;
        pipe_vld_d[0] = gpr_rden;
        pipe_sel_d[0] = rd_sel;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_sel_d[i] = pipe_sel_q[i-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rs1_q      <= '0;
            rs2_q      <= '0;
            tag_q      <= '0;
            pipe_vld_q <= '0;
            pipe_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_sel_q <= pipe_sel_d;
            if (latch) begin
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                tag_q <= in_tag;
            end
        end
    end

    // Write port: x0 is never written, and nothing is written while in reset.
    assign gpr_wren      = wb_valid && (wb_rd != X0) && !reset;
    assign gpr_wraddress = GPR_ADDR_WIDTH'(wb_rd);
    assign gpr_data      = wb_data;
    assign out_tag       = tag_q;

    rv32i_opnd_slot u_slot1 (
        .clock    (clock),
        .reset    (reset),
        .issue    (issue1),
        .ret      (ret1),
        .retire   (retire),
        .idx      (rs1_q),
        .gpr_q    (gpr_q),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .data     (out_rs1_data),
        .pending  (pend1)
    );

    rv32i_opnd_slot u_slot2 (
        .clock    (clock),
        .reset    (reset),
        .issue    (issue2),
        .ret      (ret2),
        .retire   (retire),
        .idx      (rs2_q),
        .gpr_q    (gpr_q),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .data     (out_rs2_data),
        .pending  (pend2)
    );

endmodule
